// File: rtl/yz_sample_fifo.sv
// yz_sample_fifo
// Small first-word fall-through FIFO that buffers {y,z} sample pairs
// coming out of the part06 register block. The consumer drains it with a
// valid/ready handshake. A sample offered while the FIFO is full sets the
// sticky dropped flag, which only clears on reset.
//
// Build option: define YZ_FIFO_CHANGE_ONLY_EN to skip storing a sample that
// repeats the last stored pair. The duplicate is still handshaken, so
// in_ready is unchanged, but neither the pointers nor count move.
module yz_sample_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        y,
  input  logic [1:0]        z,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_y,
  output logic [1:0]        out_z,
  output logic [ADDR_W:0]   count,
  output logic              dropped
);

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  logic [3:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_dropped;

  logic              w_full;
  logic              w_empty;
  logic              w_push_hs;
  logic              w_store;
  logic              w_pop;
  logic              w_dup;
  logic [3:0]        w_in_yz;
  logic [3:0]        w_head;

  assign w_in_yz   = {y, z};
  assign w_full    = (r_count == LP_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push_hs = in_valid & ~w_full;
  assign w_store   = w_push_hs & ~w_dup;
  assign w_pop     = ~w_empty & out_ready;

`ifdef YZ_FIFO_CHANGE_ONLY_EN
  logic [3:0] r_last_yz;
  logic       r_last_vld;

  assign w_dup = r_last_vld & (w_in_yz == r_last_yz);

  // Remember the last stored pair. Draining the FIFO leaves it in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_yz  <= 4'b0000;
      r_last_vld <= 1'b0;
    end else if (w_store) begin
      r_last_yz  <= w_in_yz;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // Sample storage. Contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_in_yz;
    end
  end

  // Pointers and occupancy. Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A suppressed duplicate would not have been stored
  // anyway, so it is not counted as lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dropped <= 1'b0;
    end else if (in_valid & w_full & ~w_dup) begin
      r_dropped <= 1'b1;
    end
  end

  // Fall-through head. It reads zero while the FIFO is empty.
  always_comb begin
    w_head = 4'b0000;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_y     = w_head[3:2];
  assign out_z     = w_head[1:0];
  assign count     = r_count;
  assign dropped   = r_dropped;

endmodule
